// File: rtl/branch_target_buffer.sv
// branch_target_buffer
// 2-way set-associative branch target buffer for the fetch stage.
// A combinational lookup on pcF reports whether pcF is a known branch and
// its predicted target. Branches resolved in M are first captured in a
// one-entry update buffer and committed to the array on the following edge.
// Lookups bypass from that buffer, so an update is visible one cycle after
// it is reported.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-high reset
//   pcF            in   fetch PC
//   branchF        out  pcF hits in the BTB
//   btb_targetF    out  predicted target, 0 on a miss
//   branchM        in   a branch/jump resolves in M this cycle
//   pcM            in   PC of the resolved branch
//   branch_targetM in   computed target of the resolved branch
//   hit_cnt        out  (BTB_STATS_EN only) cycles with branchF=1
//   alloc_cnt      out  (BTB_STATS_EN only) commits that allocated on a miss
//   evict_cnt      out  (BTB_STATS_EN only) commits that replaced a valid entry
//
// Optional feature macro: BTB_STATS_EN adds the three statistics counters.
module branch_target_buffer #(
    parameter int BTB_DEPTH = 4,
    parameter int TAG_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    output logic        branchF,
    output logic [31:0] btb_targetF,
    input  logic        branchM,
    input  logic [31:0] pcM,
    input  logic [31:0] branch_targetM
`ifdef BTB_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] alloc_cnt,
    output logic [31:0] evict_cnt
`endif
);

    localparam int SETS = 1 << BTB_DEPTH;

    // Resettable control state: valid bits and LRU bit per set
    logic [SETS-1:0] valid0_q, valid1_q, lru_q;
    logic [SETS-1:0] valid0_d, valid1_d, lru_d;

    // Tag and target storage, never reset
    logic [TAG_W-1:0] tag0_q [SETS];
    logic [TAG_W-1:0] tag1_q [SETS];
    logic [31:0]      tgt0_q [SETS];
    logic [31:0]      tgt1_q [SETS];

    // Update buffer: only the index and tag of the PC matter
    logic                 ubValid_q;
    logic [BTB_DEPTH-1:0] ubIdx_q;
    logic [TAG_W-1:0]     ubTag_q;
    logic [31:0]          ubTarget_q;

    logic [BTB_DEPTH-1:0] fIdx;
    logic [TAG_W-1:0]     fTag;
    logic                 ubHit, fHit0, fHit1;
    logic                 cHit0, cHit1, wrWay;

    // Alignment bits and PC bits above the tag do not take part in lookup
    logic unusedPcBits;
    assign unusedPcBits = ^{pcF[1:0], pcF[31:BTB_DEPTH+TAG_W+2],
                            pcM[1:0], pcM[31:BTB_DEPTH+TAG_W+2]};

    assign fIdx = pcF[BTB_DEPTH+1:2];
    assign fTag = pcF[BTB_DEPTH+TAG_W+1:BTB_DEPTH+2];

    // Lookup: the update buffer wins over the array because it holds the
    // freshest target for a PC that may also sit in a way.
    always_comb begin
        ubHit       = ubValid_q && (ubIdx_q == fIdx) && (ubTag_q == fTag);
        fHit0       = valid0_q[fIdx] && (tag0_q[fIdx] == fTag);
        fHit1       = valid1_q[fIdx] && (tag1_q[fIdx] == fTag);
        branchF     = ubHit || fHit0 || fHit1;
        btb_targetF = 32'h0;
        if (ubHit)      btb_targetF = ubTarget_q;
        else if (fHit0) btb_targetF = tgt0_q[fIdx];
        else if (fHit1) btb_targetF = tgt1_q[fIdx];
    end

    // Commit way choice: an existing tag is overwritten in place so a set
    // never holds duplicates; otherwise fill way0, then way1, then the LRU way.
    always_comb begin
        cHit0    = valid0_q[ubIdx_q] && (tag0_q[ubIdx_q] == ubTag_q);
        cHit1    = valid1_q[ubIdx_q] && (tag1_q[ubIdx_q] == ubTag_q);
        if (cHit0)                  wrWay = 1'b0;
        else if (cHit1)             wrWay = 1'b1;
        else if (!valid0_q[ubIdx_q]) wrWay = 1'b0;
        else if (!valid1_q[ubIdx_q]) wrWay = 1'b1;
        else                        wrWay = lru_q[ubIdx_q];

        valid0_d = valid0_q;
        valid1_d = valid1_q;
        lru_d    = lru_q;
        if (ubValid_q) begin
            if (wrWay) valid1_d[ubIdx_q] = 1'b1;
            else       valid0_d[ubIdx_q] = 1'b1;
            lru_d[ubIdx_q] = ~wrWay;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid0_q  <= '0;
            valid1_q  <= '0;
            lru_q     <= '0;
            ubValid_q <= 1'b0;
        end else begin
            valid0_q  <= valid0_d;
            valid1_q  <= valid1_d;
            lru_q     <= lru_d;
            ubValid_q <= branchM;
        end
    end

    // Data path: buffer capture and array write share one edge, which is
    // what lets back-to-back updates each get their own commit cycle.
    always_ff @(posedge clk) begin
        if (branchM) begin
            ubIdx_q    <= pcM[BTB_DEPTH+1:2];
            ubTag_q    <= pcM[BTB_DEPTH+TAG_W+1:BTB_DEPTH+2];
            ubTarget_q <= branch_targetM;
        end
        if (ubValid_q) begin
            if (wrWay) begin
                tag1_q[ubIdx_q] <= ubTag_q;
                tgt1_q[ubIdx_q] <= ubTarget_q;
            end else begin
                tag0_q[ubIdx_q] <= ubTag_q;
                tgt0_q[ubIdx_q] <= ubTarget_q;
            end
        end
    end

`ifdef BTB_STATS_EN
    logic        commitAlloc, commitEvict;
    logic [31:0] hitCnt_q, allocCnt_q, evictCnt_q;

    assign commitAlloc = ubValid_q && !cHit0 && !cHit1;
    assign commitEvict = commitAlloc && valid0_q[ubIdx_q] && valid1_q[ubIdx_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hitCnt_q   <= '0;
            allocCnt_q <= '0;
            evictCnt_q <= '0;
        end else begin
            hitCnt_q   <= hitCnt_q + 32'(branchF);
            allocCnt_q <= allocCnt_q + 32'(commitAlloc);
            evictCnt_q <= evictCnt_q + 32'(commitEvict);
        end
    end

    assign hit_cnt   = hitCnt_q;
    assign alloc_cnt = allocCnt_q;
    assign evict_cnt = evictCnt_q;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer
// Directed and randomized checks of branch_target_buffer against a
// recency-list model: each set is a list of at most two {tag,target} entries
// ordered oldest first, plus one pending update that is visible immediately.
module tb_branch_target_buffer;

    logic        clk;
    logic        rst;
    logic [31:0] pcF;
    logic        branchF;
    logic [31:0] btb_targetF;
    logic        branchM;
    logic [31:0] pcM;
    logic [31:0] branch_targetM;

    int checks = 0;
    int errors = 0;

`ifdef BTB_STATS_EN
    logic [31:0] hitCntW, allocCntW, evictCntW;
`endif

    branch_target_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .pcF            (pcF),
        .branchF        (branchF),
        .btb_targetF    (btb_targetF),
        .branchM        (branchM),
        .pcM            (pcM),
        .branch_targetM (branch_targetM)
`ifdef BTB_STATS_EN
        ,
        .hit_cnt        (hitCntW),
        .alloc_cnt      (allocCntW),
        .evict_cnt      (evictCntW)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int          mCnt [16];
    logic [7:0]  mTag [16][2];
    logic [31:0] mTgt [16][2];
    logic        pendValid;
    logic [31:0] pendPc;
    logic [31:0] pendTgt;

    task automatic modelReset();
        for (int i = 0; i < 16; i++) mCnt[i] = 0;
        pendValid = 1'b0;
    endtask

    // Insert or refresh an entry as most recent; a full set drops its oldest
    task automatic modelCommit(input logic [31:0] pc, input logic [31:0] tgt);
        int         s;
        logic [7:0] t;
        int         pos;
        s   = int'(pc[5:2]);
        t   = pc[13:6];
        pos = -1;
        for (int i = 0; i < mCnt[s]; i++)
            if (mTag[s][i] == t) pos = i;
        if (pos < 0 && mCnt[s] == 2) pos = 0;
        if (pos >= 0) begin
            for (int j = pos; j < mCnt[s] - 1; j++) begin
                mTag[s][j] = mTag[s][j+1];
                mTgt[s][j] = mTgt[s][j+1];
            end
            mCnt[s] = mCnt[s] - 1;
        end
        mTag[s][mCnt[s]] = t;
        mTgt[s][mCnt[s]] = tgt;
        mCnt[s] = mCnt[s] + 1;
    endtask

    function automatic logic [32:0] modelLookup(input logic [31:0] pf);
        logic [32:0] r;
        int          s;
        r = 33'h0;
        s = int'(pf[5:2]);
        if (pendValid && pendPc[13:2] == pf[13:2]) begin
            r = {1'b1, pendTgt};
        end else begin
            for (int i = 0; i < mCnt[s]; i++)
                if (mTag[s][i] == pf[13:6]) r = {1'b1, mTgt[s][i]};
        end
        return r;
    endfunction

    // One clock: drive inputs, take the edge, advance the model, settle
    task automatic applyStimulus(input logic bm, input logic [31:0] pm,
                                 input logic [31:0] tm, input logic [31:0] pf);
        branchM        = bm;
        pcM            = pm;
        branch_targetM = tm;
        pcF            = pf;
        @(posedge clk);
        if (pendValid) modelCommit(pendPc, pendTgt);
        pendValid = bm;
        pendPc    = pm;
        pendTgt   = tm;
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic [32:0] exp;
        exp = modelLookup(pcF);
        checks++;
        assert (branchF === exp[32]) else begin
            errors++;
            $error("FAIL %s branchF pc=%h got %b exp %b", tag, pcF, branchF, exp[32]);
        end
        checks++;
        assert (btb_targetF === exp[31:0]) else begin
            errors++;
            $error("FAIL %s target pc=%h got %h exp %h", tag, pcF, btb_targetF, exp[31:0]);
        end
    endtask

    task automatic checkKnown(input string tag, input logic expB, input logic [31:0] expT);
        checks++;
        assert (branchF === expB && btb_targetF === expT) else begin
            errors++;
            $error("FAIL %s pc=%h got %b/%h exp %b/%h", tag, pcF, branchF, btb_targetF, expB, expT);
        end
    endtask

    task automatic probe(input logic [31:0] pf, input string tag,
                         input logic expB, input logic [31:0] expT);
        pcF = pf;
        #1;
        checkKnown(tag, expB, expT);
        checkOutput(tag);
    endtask

    task automatic doReset();
        branchM = 1'b0;
        rst     = 1'b1;
        modelReset();
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic        bm;
        logic [31:0] pm, pf;
        rst = 1'b1;
        branchM = 1'b0;
        pcM = 32'h0;
        branch_targetM = 32'h0;
        pcF = 32'h40;
        modelReset();
        pendPc = 32'h0;
        pendTgt = 32'h0;
        #1;
        checkKnown("reset_out", 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        probe(32'h40, "post_reset", 1'b0, 32'h0);

        // Bypass then array visibility
        applyStimulus(1'b1, 32'h40, 32'h100, 32'h40);
        checkKnown("bypass", 1'b1, 32'h100);
        checkOutput("bypass");
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h40);
        checkKnown("array", 1'b1, 32'h100);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h40);
        checkKnown("array2", 1'b1, 32'h100);

        // Three installs into set 0 evict the oldest
        doReset();
        applyStimulus(1'b1, 32'h40, 32'h100, 32'h0);
        applyStimulus(1'b1, 32'h80, 32'h200, 32'h0);
        applyStimulus(1'b1, 32'hC0, 32'h300, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
        probe(32'h40, "evict_40", 1'b0, 32'h0);
        probe(32'h80, "keep_80", 1'b1, 32'h200);
        probe(32'hC0, "keep_C0", 1'b1, 32'h300);

        // Same PC twice back to back leaves one entry
        doReset();
        applyStimulus(1'b1, 32'h40, 32'h100, 32'h0);
        applyStimulus(1'b1, 32'h40, 32'h180, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
        probe(32'h40, "dup_40", 1'b1, 32'h180);
        applyStimulus(1'b1, 32'h80, 32'h200, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
        probe(32'h40, "dup_keep40", 1'b1, 32'h180);
        probe(32'h80, "dup_80", 1'b1, 32'h200);

        // Aliasing false hit and different set miss
        doReset();
        applyStimulus(1'b1, 32'h40, 32'h100, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
        probe(32'h4040, "alias", 1'b1, 32'h100);
        probe(32'h44, "set1_miss", 1'b0, 32'h0);

        // Sixteen consecutive updates, one per set
        doReset();
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b1, 32'(i * 4), 32'h1000 + 32'(i * 16), 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 32'(i * 4));
            checkKnown("burst", 1'b1, 32'h1000 + 32'(i * 16));
        end

        // Reset while an update is pending in the buffer
        applyStimulus(1'b1, 32'h200, 32'h240, 32'h200);
        checkKnown("pend_hit", 1'b1, 32'h240);
        rst = 1'b1;
        modelReset();
        #1;
        checkKnown("rst_async", 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h200);
        checkKnown("rst_drop", 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h200);
        checkKnown("rst_drop2", 1'b0, 32'h0);
        probe(32'h4, "rst_cleared", 1'b0, 32'h0);

        // Randomized traffic over a small PC pool to force hits and evictions
        for (int n = 0; n < 600; n++) begin
            bm = 1'($urandom_range(0, 1));
            pm = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) |
                 ($urandom_range(0, 1) << 14) | $urandom_range(0, 3);
            pf = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) |
                 ($urandom_range(0, 1) << 15);
            applyStimulus(bm, pm, $urandom, pf);
            checkOutput("rand");
            if (n % 7 == 0) begin
                pcF = pm;
                #1;
                checkOutput("rand_same");
            end
            if (n == 300) doReset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
